draw_highlight_start: RTL

Overlay stage placed directly downstream of the start-screen character drawer. It takes the finished start-screen VGA stream and draws a rectangular border around the menu text box. The border blinks while the menu is idle, stays solid while the pointer hovers over the box, and is absent when disabled. All stream signals pass through with one registered cycle of latency, so the timing and pixel data stay aligned.

---
 rtl/draw_highlight_start.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/draw_highlight_start.sv
// Start-screen overlay: draws a blinking/solid rectangular border around the menu box
// on top of the incoming VGA stream, with every stream field registered once.
module draw_highlight_start #(
    parameter int          X_POS        = 384,
    parameter int          Y_POS        = 240,
    parameter int          WIDTH        = 256,
    parameter int          HEIGHT       = 64,
    parameter int          BORDER       = 4,
    parameter logic [11:0] COLOR        = 12'hFF0,
    parameter int          BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        hover,
    input  logic [10:0] in_hcount,
    input  logic [10:0] in_vcount,
    input  logic        in_hsync,
    input  logic        in_vsync,
    input  logic        in_hblnk,
    input  logic        in_vblnk,
    input  logic [11:0] in_rgb,
    output logic [10:0] out_hcount,
    output logic [10:0] out_vcount,
    output logic        out_hsync,
    output logic        out_vsync,
    output logic        out_hblnk,
    output logic        out_vblnk,
    output logic [11:0] out_rgb
);

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        ON    = 2'd1,
        BLANK = 2'd2,
        SOLID = 2'd3
    } state_t;

    // Box edges widened to 12 bits so X_POS+WIDTH cannot wrap the 11-bit counters.
    localparam logic [11:0] X_LO  = 12'(X_POS);
    localparam logic [11:0] X_HI  = 12'(X_POS + WIDTH);
    localparam logic [11:0] XI_LO = 12'(X_POS + BORDER);
    localparam logic [11:0] XI_HI = 12'(X_POS + WIDTH - BORDER);
    localparam logic [11:0] Y_LO  = 12'(Y_POS);
    localparam logic [11:0] Y_HI  = 12'(Y_POS + HEIGHT);
    localparam logic [11:0] YI_LO = 12'(Y_POS + BORDER);
    localparam logic [11:0] YI_HI = 12'(Y_POS + HEIGHT - BORDER);
    localparam logic [7:0]  BLINK_LAST = 8'(BLINK_FRAMES - 1);

    state_t      state_reg;
    state_t      state_next;
    logic [7:0]  count_reg;
    logic [7:0]  count_next;
    logic        vblnk_prev_reg;
    logic        frame_tick;
    logic [11:0] h_ext;
    logic [11:0] v_ext;
    logic        in_outer;
    logic        in_inner;
    logic        border_pixel;
    logic        draw_on;
    logic [11:0] rgb_next;

    assign frame_tick = in_vblnk & ~vblnk_prev_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= OFF;
            count_reg      <= '0;
            vblnk_prev_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            count_reg      <= count_next;
            vblnk_prev_reg <= in_vblnk;
        end
    end

    // Disable overrides everything; every other move waits for a frame tick.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        if (!enable) begin
            state_next = OFF;
            count_next = '0;
        end else if (frame_tick) begin
            case (state_reg)
                OFF: begin
                    state_next = ON;
                    count_next = '0;
                end
                ON, BLANK: begin
                    if (hover) begin
                        state_next = SOLID;
                        count_next = '0;
                    end else if (count_reg == BLINK_LAST) begin
                        state_next = (state_reg == ON) ? BLANK : ON;
                        count_next = '0;
                    end else begin
                        count_next = count_reg + 8'd1;
                    end
                end
                SOLID: begin
                    if (!hover) begin
                        state_next = ON;
                        count_next = '0;
                    end
                end
                default: begin
                    state_next = OFF;
                    count_next = '0;
                end
            endcase
        end
    end

    assign h_ext = {1'b0, in_hcount};
    assign v_ext = {1'b0, in_vcount};

    always_comb begin
        in_outer     = (h_ext >= X_LO) && (h_ext < X_HI) && (v_ext >= Y_LO) && (v_ext < Y_HI);
        in_inner     = (h_ext >= XI_LO) && (h_ext < XI_HI) && (v_ext >= YI_LO) && (v_ext < YI_HI);
        border_pixel = in_outer && !in_inner;
        draw_on      = (state_reg == ON) || (state_reg == SOLID);
        rgb_next     = in_rgb;
        if (in_hblnk || in_vblnk) begin
            rgb_next = 12'h000;
        end else if (draw_on && border_pixel) begin
            rgb_next = COLOR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_hcount <= '0;
            out_vcount <= '0;
            out_hsync  <= 1'b0;
            out_vsync  <= 1'b0;
            out_hblnk  <= 1'b0;
            out_vblnk  <= 1'b0;
            out_rgb    <= '0;
        end else begin
            out_hcount <= in_hcount;
            out_vcount <= in_vcount;
            out_hsync  <= in_hsync;
            out_vsync  <= in_vsync;
            out_hblnk  <= in_hblnk;
            out_vblnk  <= in_vblnk;
            out_rgb    <= rgb_next;
        end
    end

endmodule
